// File: rtl/imm_extend_unit_if.sv
// rtl/imm_extend_unit_if.sv - instruction-in / immediate-out bundle for the immediate extend unit
interface imm_extend_unit_if #(
  parameter int DATA_W  = 16,
  parameter int FIELD_W = 4
);
  // instruction side (driven by the decode front end)
  logic               in_valid;
  logic [FIELD_W-1:0] opcode;
  logic [FIELD_W-1:0] one;
  logic [FIELD_W-1:0] two;
  logic [FIELD_W-1:0] three;
  logic               zext;
  logic               stall;
  logic               flush;
  // immediate side (consumed by the ID/EX register)
  logic [DATA_W-1:0]  imm_out;
  logic               out_valid;
  logic               pfx_used;
  logic               pfx_armed;

  modport master (
    output in_valid, opcode, one, two, three, zext, stall, flush,
    input  imm_out, out_valid, pfx_used, pfx_armed
  );

  modport slave (
    input  in_valid, opcode, one, two, three, zext, stall, flush,
    output imm_out, out_valid, pfx_used, pfx_armed
  );
endinterface

// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - registered A/B/C/D immediate generator with prefix fusion
module imm_extend_unit #(
  parameter int                 DATA_W    = 16,
  parameter int                 FIELD_W   = 4,
  parameter logic [FIELD_W-1:0] PREFIX_OP = 4'b1110
) (
  input logic              clk,
  input logic              rst,
  imm_extend_unit_if.slave bus
);

  localparam int RAW_W = 4 * FIELD_W;

  typedef enum logic {IDLE, ARMED} state_e;

  state_e               state_q;
  logic [3*FIELD_W-1:0] pfx_q;
  logic [DATA_W-1:0]    imm_q;
  logic                 out_valid_q;
  logic                 pfx_used_q;
  logic                 pfx_armed_q;

  logic [3*FIELD_W-1:0] fields;
  logic [3*FIELD_W-1:0] base;
  logic                 base_sign;
  int                   base_w;
  logic [RAW_W-1:0]     raw;
  logic                 raw_sign;
  int                   raw_w;
  logic                 fill;
  logic [DATA_W-1:0]    mask;
  logic [DATA_W-1:0]    imm_d;
  logic                 is_pfx;
  logic                 accept;

  // Format decode, optional prefix fusion and sign/zero extension of the result
  always_comb begin
    fields    = {bus.one, bus.two, bus.three};
    base      = '0;
    base_sign = 1'b0;
    base_w    = FIELD_W;
    case (bus.opcode)
      FIELD_W'(4'b1000), FIELD_W'(4'b1011): begin
        base      = {{(2*FIELD_W){1'b0}}, bus.three};
        base_sign = bus.three[FIELD_W-1];
        base_w    = FIELD_W;
      end
      FIELD_W'(4'b0100), FIELD_W'(4'b0101), FIELD_W'(4'b0110): begin
        base      = {{FIELD_W{1'b0}}, bus.two, bus.three};
        base_sign = bus.two[FIELD_W-1];
        base_w    = 2 * FIELD_W;
      end
      FIELD_W'(4'b1100), FIELD_W'(4'b1111): begin
        base      = fields;
        base_sign = bus.one[FIELD_W-1];
        base_w    = 3 * FIELD_W;
      end
      default: begin
        base      = {{(2*FIELD_W){1'b0}}, bus.two};
        base_sign = bus.two[FIELD_W-1];
        base_w    = FIELD_W;
      end
    endcase

    // A pending prefix supplies the upper bits; only the low field of the base survives
    if (state_q == ARMED) begin
      raw      = {pfx_q, base[FIELD_W-1:0]};
      raw_sign = pfx_q[3*FIELD_W-1];
      raw_w    = RAW_W;
    end else begin
      raw      = RAW_W'(base);
      raw_sign = base_sign;
      raw_w    = base_w;
    end

    fill  = ~bus.zext & raw_sign;
    mask  = ~({DATA_W{1'b1}} << raw_w);
    imm_d = (DATA_W'(raw) & mask) | ({DATA_W{fill}} & ~mask);

    is_pfx = (bus.opcode == PREFIX_OP);
    accept = bus.in_valid & ~bus.stall & ~bus.flush;
  end

  // Prefix FSM and output registers; flush beats stall beats accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pfx_q       <= '0;
      imm_q       <= '0;
      out_valid_q <= 1'b0;
      pfx_used_q  <= 1'b0;
      pfx_armed_q <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= IDLE;
      pfx_q       <= '0;
      out_valid_q <= 1'b0;
      pfx_used_q  <= 1'b0;
      pfx_armed_q <= 1'b0;
    end else if (bus.stall) begin
      state_q     <= state_q;
    end else if (accept) begin
      if (is_pfx) begin
        // A prefix only loads upper bits; it never produces an immediate itself
        state_q     <= ARMED;
        pfx_q       <= fields;
        out_valid_q <= 1'b0;
        pfx_used_q  <= 1'b0;
        pfx_armed_q <= 1'b1;
      end else begin
        state_q     <= IDLE;
        imm_q       <= imm_d;
        out_valid_q <= 1'b1;
        pfx_used_q  <= (state_q == ARMED);
        pfx_armed_q <= 1'b0;
      end
    end else begin
      // Idle cycle: the immediate holds, an armed prefix waits indefinitely
      out_valid_q <= 1'b0;
      pfx_used_q  <= 1'b0;
    end
  end

  assign bus.imm_out   = imm_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pfx_used  = pfx_used_q;
  assign bus.pfx_armed = pfx_armed_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb/tb_imm_extend_unit.sv - directed-vector bench for imm_extend_unit
module tb_imm_extend_unit;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  imm_extend_unit_if #(.DATA_W(16), .FIELD_W(4)) bus ();

  imm_extend_unit #(.DATA_W(16), .FIELD_W(4), .PREFIX_OP(4'b1110)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] f1,
                       input logic [3:0] f2, input logic [3:0] f3, input logic z,
                       input logic st, input logic fl);
    bus.in_valid = v;
    bus.opcode   = op;
    bus.one      = f1;
    bus.two      = f2;
    bus.three    = f3;
    bus.zext     = z;
    bus.stall    = st;
    bus.flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.imm_out !== 16'h0000) begin miscompares++; $display("FAIL reset_imm: got %h want 0000", bus.imm_out); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.pfx_used !== 1'b0) begin miscompares++; $display("FAIL reset_used: got %b want 0", bus.pfx_used); end
    vectors++; if (bus.pfx_armed !== 1'b0) begin miscompares++; $display("FAIL reset_armed: got %b want 0", bus.pfx_armed); end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_format_a();
    drive(1'b1, 4'h0, 4'h0, 4'hA, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.imm_out !== 16'hFFFA) begin miscompares++; $display("FAIL a_sext_imm: got %h want FFFA", bus.imm_out); end
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL a_sext_valid: got %b want 1", bus.out_valid); end
    vectors++; if (bus.pfx_used !== 1'b0) begin miscompares++; $display("FAIL a_sext_used: got %b want 0", bus.pfx_used); end
    drive(1'b1, 4'h3, 4'h9, 4'hF, 4'h9, 1'b1, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.imm_out !== 16'h000F) begin miscompares++; $display("FAIL a_zext_imm: got %h want 000F", bus.imm_out); end
  endtask

  task automatic test_idle_hold();
    drive(1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.imm_out !== 16'h000F) begin miscompares++; $display("FAIL idle_imm: got %h want 000F", bus.imm_out); end
  endtask

  task automatic test_format_c();
    drive(1'b1, 4'b0100, 4'h0, 4'h7, 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.imm_out !== 16'h007F) begin miscompares++; $display("FAIL c_pos_imm: got %h want 007F", bus.imm_out); end
    drive(1'b1, 4'b0101, 4'h0, 4'h8, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.imm_out !== 16'hFF80) begin miscompares++; $display("FAIL c_neg_imm: got %h want FF80", bus.imm_out); end
    drive(1'b1, 4'b0110, 4'h0, 4'h8, 4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.imm_out !== 16'h0080) begin miscompares++; $display("FAIL c_zext_imm: got %h want 0080", bus.imm_out); end
  endtask

  task automatic test_format_bd();
    drive(1'b1, 4'b1011, 4'h0, 4'h0, 4'h9, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.imm_out !== 16'hFFF9) begin miscompares++; $display("FAIL b_sext_imm: got %h want FFF9", bus.imm_out); end
    drive(1'b1, 4'b1111, 4'h8, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.imm_out !== 16'hF800) begin miscompares++; $display("FAIL d_sext_imm: got %h want F800", bus.imm_out); end
  endtask

  task automatic test_prefix_fuse();
    drive(1'b1, 4'b1110, 4'h8, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL pfx_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.pfx_armed !== 1'b1) begin miscompares++; $display("FAIL pfx_armed: got %b want 1", bus.pfx_armed); end
    drive(1'b1, 4'b1000, 4'h0, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.imm_out !== 16'h8125) begin miscompares++; $display("FAIL fuse_imm: got %h want 8125", bus.imm_out); end
    vectors++; if (bus.pfx_used !== 1'b1) begin miscompares++; $display("FAIL fuse_used: got %b want 1", bus.pfx_used); end
    vectors++; if (bus.pfx_armed !== 1'b0) begin miscompares++; $display("FAIL fuse_armed: got %b want 0", bus.pfx_armed); end
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL fuse_valid: got %b want 1", bus.out_valid); end
  endtask

  task automatic test_prefix_overwrite();
    drive(1'b1, 4'b1110, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL ovw_valid1: got %b want 0", bus.out_valid); end
    drive(1'b1, 4'b1110, 4'h4, 4'h5, 4'h6, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL ovw_valid2: got %b want 0", bus.out_valid); end
    vectors++; if (bus.pfx_armed !== 1'b1) begin miscompares++; $display("FAIL ovw_armed: got %b want 1", bus.pfx_armed); end
    drive(1'b0, 4'b1100, 4'h0, 4'h0, 4'h7, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.pfx_armed !== 1'b1) begin miscompares++; $display("FAIL ovw_wait_armed: got %b want 1", bus.pfx_armed); end
    drive(1'b1, 4'b1100, 4'h0, 4'h0, 4'h7, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.imm_out !== 16'h4567) begin miscompares++; $display("FAIL ovw_imm: got %h want 4567", bus.imm_out); end
    vectors++; if (bus.pfx_used !== 1'b1) begin miscompares++; $display("FAIL ovw_used: got %b want 1", bus.pfx_used); end
  endtask

  task automatic test_flush();
    drive(1'b1, 4'b1110, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'h0, 4'h0, 4'h9, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.pfx_armed !== 1'b0) begin miscompares++; $display("FAIL flush_armed: got %b want 0", bus.pfx_armed); end
    drive(1'b1, 4'h0, 4'h0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.imm_out !== 16'h0003) begin miscompares++; $display("FAIL flush_next_imm: got %h want 0003", bus.imm_out); end
    vectors++; if (bus.pfx_used !== 1'b0) begin miscompares++; $display("FAIL flush_next_used: got %b want 0", bus.pfx_used); end
  endtask

  task automatic test_stall();
    drive(1'b1, 4'b1100, 4'h7, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (bus.imm_out !== 16'h0003) begin miscompares++; $display("FAIL stall_imm[%0d]: got %h want 0003", i, bus.imm_out); end
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.out_valid); end
    end
    bus.stall = 1'b0;
    tick();
    vectors++; if (bus.imm_out !== 16'h07FF) begin miscompares++; $display("FAIL stall_release_imm: got %h want 07FF", bus.imm_out); end
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_release_valid: got %b want 1", bus.out_valid); end
  endtask

  task automatic test_reset_armed();
    drive(1'b1, 4'b1110, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.pfx_armed !== 1'b1) begin miscompares++; $display("FAIL rst_pre_armed: got %b want 1", bus.pfx_armed); end
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (bus.imm_out !== 16'h0000) begin miscompares++; $display("FAIL rst_async_imm: got %h want 0000", bus.imm_out); end
    vectors++; if (bus.pfx_armed !== 1'b0) begin miscompares++; $display("FAIL rst_async_armed: got %b want 0", bus.pfx_armed); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_async_valid: got %b want 0", bus.out_valid); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 4'b1011, 4'h0, 4'h0, 4'h6, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.imm_out !== 16'h0006) begin miscompares++; $display("FAIL rst_after_imm: got %h want 0006", bus.imm_out); end
    vectors++; if (bus.pfx_used !== 1'b0) begin miscompares++; $display("FAIL rst_after_used: got %b want 0", bus.pfx_used); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_format_a();
    test_idle_hold();
    test_format_c();
    test_format_bd();
    test_prefix_fuse();
    test_prefix_overwrite();
    test_flush();
    test_stall();
    test_reset_armed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
